// File: rtl/param_data_memory.sv
// -----------------------------------------------------------------------------
// param_data_memory
//
// Line-granular backing memory for the L1 data cache. A request is accepted
// while the block is idle. Its address, write data and byte mask are latched
// at that point. The block then runs a fixed LATENCY-cycle countdown. On the
// completing edge it performs the read or masked write and raises ack_o for
// one cycle.
//
// Optional feature macro: DMEM_RANGE_CHECK_EN
//   When defined, the err_o port exists. An address with any bit set above
//   the line index field is treated as out of range: the write is dropped,
//   or the read returns zero, and err_o pulses together with ack_o.
//   When undefined, the upper address bits simply alias.
//
// Ports
//   clk_i    in   1          clock, rising edge
//   rst_i    in   1          asynchronous reset, active-low
//   req_i    in   1          request strobe, sampled only while busy_o=0
//   write_i  in   1          1=write, 0=read
//   addr_i   in   ADDR_BITS  byte address; line index = addr_i[OFF+IDX-1:OFF]
//   data_i   in   LINE_BITS  write line
//   mask_i   in   MASK_BITS  byte write enables
//   busy_o   out  1          request in flight
//   ack_o    out  1          one-cycle completion pulse
//   data_o   out  LINE_BITS  read line, held until the next read ack
//   err_o    out  1          range error (DMEM_RANGE_CHECK_EN only)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module param_data_memory #(
  parameter int LINE_BITS = 256,
  parameter int DEPTH     = 512,
  parameter int ADDR_BITS = 32,
  parameter int LATENCY   = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  input  logic                   write_i,
  input  logic [ADDR_BITS-1:0]   addr_i,
  input  logic [LINE_BITS-1:0]   data_i,
  input  logic [LINE_BITS/8-1:0] mask_i,
  output logic                   busy_o,
  output logic                   ack_o,
  output logic [LINE_BITS-1:0]   data_o
`ifdef DMEM_RANGE_CHECK_EN
  ,
  output logic                   err_o
`endif
);

  localparam int MASK_BITS = LINE_BITS / 8;
  localparam int OFF       = $clog2(MASK_BITS);
  localparam int IDX       = $clog2(DEPTH);
  localparam int CNT_W     = $clog2(LATENCY + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_ack;
  logic [LINE_BITS-1:0] r_data_out;

  // Request fields captured at acceptance; these need no reset because they
  // are only consumed while the FSM is in S_WAIT.
  logic                 r_write;
  logic [IDX-1:0]       r_idx;
  logic [LINE_BITS-1:0] r_wdata;
  logic [MASK_BITS-1:0] r_mask;

  logic                 w_accept;
  logic                 w_done;
  logic                 w_suppress;
  logic [LINE_BITS-1:0] w_rd_line;
  logic                 w_unused_addr;

  assign w_accept = (r_state == S_IDLE) && req_i;
  assign w_done   = (r_state == S_WAIT) && (r_cnt == CNT_W'(LATENCY - 1));

  // Bits outside the index field take no part in the default build; fold them
  // into a sink so they are visibly intentional.
  assign w_unused_addr = ^addr_i;

`ifdef DMEM_RANGE_CHECK_EN
  logic r_range_err;
  logic r_err;

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_range_err <= |addr_i[ADDR_BITS-1:OFF+IDX];
    end
  end

  assign w_suppress = r_range_err;
  assign err_o      = r_err;
`else
  assign w_suppress = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_write <= write_i;
      r_idx   <= addr_i[OFF+IDX-1:OFF];
      r_wdata <= data_i;
      r_mask  <= mask_i;
    end
  end

  // One narrow array per byte lane gives each lane its own write enable. This
  // is the usual byte-write RAM shape and avoids partial writes to one array.
  genvar gi;
  generate
    for (gi = 0; gi < MASK_BITS; gi++) begin : g_lane
      logic [7:0] r_lane [DEPTH];

      always_ff @(posedge clk_i) begin
        if (w_done && r_write && !w_suppress && r_mask[gi]) begin
          r_lane[r_idx] <= r_wdata[8*gi +: 8];
        end
      end

      assign w_rd_line[8*gi +: 8] = r_lane[r_idx];
    end
  endgenerate

  // Control path. A reset while a write is in flight returns the FSM to idle,
  // so w_done never fires and the pending write is dropped without an ack.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_ack      <= 1'b0;
      r_data_out <= '0;
`ifdef DMEM_RANGE_CHECK_EN
      r_err      <= 1'b0;
`endif
    end else begin
      r_ack <= 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
      r_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (req_i) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_done) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b1;
            if (!r_write) begin
              r_data_out <= w_suppress ? '0 : w_rd_line;
            end
`ifdef DMEM_RANGE_CHECK_EN
            r_err <= r_range_err;
`endif
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o = (r_state == S_WAIT);
  assign ack_o  = r_ack;
  assign data_o = r_data_out;

endmodule

// File: tb/tb_param_data_memory.sv
`timescale 1ns/1ps

module tb_param_data_memory;

  // Clock: shared by both instances.
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance signals (defaults, LATENCY = 10).
  logic         rst_n;
  logic         req;
  logic         wr;
  logic [31:0]  addr;
  logic [255:0] wdata;
  logic [31:0]  mask;
  logic         busy;
  logic         ack;
  logic [255:0] rdata;

  // Second instance signals (LATENCY = 1).
  logic         rst1_n;
  logic         req1;
  logic         wr1;
  logic [31:0]  addr1;
  logic [255:0] wdata1;
  logic [31:0]  mask1;
  logic         busy1;
  logic         ack1;
  logic [255:0] rdata1;

`ifdef DMEM_RANGE_CHECK_EN
  logic err;
  logic err1;
`endif

  param_data_memory dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .req_i   (req),
    .write_i (wr),
    .addr_i  (addr),
    .data_i  (wdata),
    .mask_i  (mask),
    .busy_o  (busy),
    .ack_o   (ack),
    .data_o  (rdata)
`ifdef DMEM_RANGE_CHECK_EN
    ,
    .err_o   (err)
`endif
  );

  param_data_memory #(.LATENCY(1)) dut1 (
    .clk_i   (clk),
    .rst_i   (rst1_n),
    .req_i   (req1),
    .write_i (wr1),
    .addr_i  (addr1),
    .data_i  (wdata1),
    .mask_i  (mask1),
    .busy_o  (busy1),
    .ack_o   (ack1),
    .data_o  (rdata1)
`ifdef DMEM_RANGE_CHECK_EN
    ,
    .err_o   (err1)
`endif
  );

  int n_cmp = 0;
  int n_mis = 0;

  localparam logic [255:0] L_A5   = {32{8'hA5}};
  localparam logic [255:0] L_11   = {32{8'h11}};
  localparam logic [255:0] L_FF   = {32{8'hFF}};
  localparam logic [255:0] L_22   = {32{8'h22}};
  localparam logic [255:0] L_3C   = {32{8'h3C}};
  localparam logic [255:0] L_5A   = {32{8'h5A}};
  localparam logic [255:0] L_C3   = {32{8'hC3}};
  localparam logic [255:0] L_0F   = {32{8'h0F}};
  localparam logic [255:0] L_F0   = {32{8'hF0}};
  localparam logic [255:0] L_11FF = {{31{8'h11}}, 8'hFF};
  localparam logic [31:0]  M_ALL  = 32'hFFFF_FFFF;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request on the main instance starting #1 after an edge while
  // idle. Returns the edge count from accept to ack (-1 if no ack in budget).
  task automatic op(input logic w, input logic [31:0] a, input logic [255:0] d,
                    input logic [31:0] m, output int lat, output logic e);
    req = 1'b1; wr = w; addr = a; wdata = d; mask = m;
    @(posedge clk); #1;
    req = 1'b0; wdata = '0; mask = '0;
    lat = -1;
    e   = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (ack) begin
        lat = n;
`ifdef DMEM_RANGE_CHECK_EN
        e = err;
`endif
        break;
      end
    end
    $display("op wr=%0b addr=%h lat=%0d data_o=%h", w, a, lat, rdata);
  endtask

  initial begin
    int   lat;
    logic e;
    int   n_ack;
    logic exp_ack;

    rst_n = 1'b1; rst1_n = 1'b1;
    req = 1'b0; wr = 1'b0; addr = '0; wdata = '0; mask = '0;
    req1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0; mask1 = '0;
    #2;
    rst_n = 1'b0; rst1_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_ack", 256'(ack), 256'(0));
    chk("rst_data", rdata, '0);
    chk("rst1_busy", 256'(busy1), 256'(0));
    rst_n = 1'b1; rst1_n = 1'b1;
    @(posedge clk); #1;

    // 1: full write then read of 0x40
    op(1'b1, 32'h40, L_A5, M_ALL, lat, e);
    chk("t1_wr_lat", 256'(lat), 256'(10));
    chk("t1_wr_data_hold", rdata, '0);
    op(1'b0, 32'h40, '0, '0, lat, e);
    chk("t1_rd_lat", 256'(lat), 256'(10));
    chk("t1_rd_data", rdata, L_A5);
    @(posedge clk); #1;
    chk("t1_ack_fall", 256'(ack), 256'(0));
    chk("t1_data_held", rdata, L_A5);
`ifndef DMEM_RANGE_CHECK_EN
    // Upper and offset address bits alias onto line index 2.
    op(1'b0, 32'h405F, '0, '0, lat, e);
    chk("alias_rd_data", rdata, L_A5);
`endif

    // 2: byte mask and empty mask
    op(1'b1, 32'h80, L_11, M_ALL, lat, e);
    op(1'b1, 32'h80, L_FF, 32'h0000_0001, lat, e);
    op(1'b1, 32'h80, L_22, 32'h0, lat, e);
    chk("t2_mask0_lat", 256'(lat), 256'(10));
    op(1'b0, 32'h80, '0, '0, lat, e);
    chk("t2_rd_data", rdata, L_11FF);

    // 3: req held high; only one request per LATENCY+1 cycles is taken
    op(1'b1, 32'h0, L_3C, M_ALL, lat, e);
    req = 1'b1; wr = 1'b0; addr = 32'h0;
    @(posedge clk); #1;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      exp_ack = (k == 10) || (k == 21) || (k == 32);
      chk($sformatf("t3_ack_E%0d", k), 256'(ack), 256'(exp_ack));
      chk($sformatf("t3_busy_E%0d", k), 256'(busy), 256'(!exp_ack));
      if (exp_ack) begin
        chk($sformatf("t3_data_E%0d", k), rdata, L_3C);
        $display("t3 ack at E%0d data_o=%h", k, rdata);
      end
    end
    req = 1'b0;

    // 4: reset during an in-flight write drops it
    op(1'b1, 32'h100, L_5A, M_ALL, lat, e);
    req = 1'b1; wr = 1'b1; addr = 32'h100; wdata = L_C3; mask = M_ALL;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t4_rst_busy", 256'(busy), 256'(0));
    chk("t4_rst_ack", 256'(ack), 256'(0));
    chk("t4_rst_data", rdata, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_ack = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (ack) n_ack++;
    end
    chk("t4_no_ack", 256'(n_ack), 256'(0));
    op(1'b0, 32'h100, '0, '0, lat, e);
    chk("t4_rd_lat", 256'(lat), 256'(10));
    chk("t4_rd_data", rdata, L_5A);

    // 5: LATENCY=1 instance, preload two lines then back-to-back reads
    for (int i = 0; i < 2; i++) begin
      req1 = 1'b1; wr1 = 1'b1; addr1 = 32'(i * 32);
      wdata1 = (i == 0) ? L_0F : L_F0; mask1 = M_ALL;
      @(posedge clk); #1;
      req1 = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("t5_wr%0d_ack", i), 256'(ack1), 256'(1));
    end
    req1 = 1'b1; wr1 = 1'b0; addr1 = 32'h0;
    @(posedge clk); #1;
    chk("t5_e0_ack", 256'(ack1), 256'(0));
    chk("t5_e0_busy", 256'(busy1), 256'(1));
    addr1 = 32'h20;
    @(posedge clk); #1;
    chk("t5_e1_ack", 256'(ack1), 256'(1));
    chk("t5_e1_busy", 256'(busy1), 256'(0));
    chk("t5_e1_data", rdata1, L_0F);
    $display("t5 first read ack data_o=%h", rdata1);
    @(posedge clk); #1;
    chk("t5_e2_ack", 256'(ack1), 256'(0));
    chk("t5_e2_busy", 256'(busy1), 256'(1));
    req1 = 1'b0;
    @(posedge clk); #1;
    chk("t5_e3_ack", 256'(ack1), 256'(1));
    chk("t5_e3_data", rdata1, L_F0);
    $display("t5 second read ack data_o=%h", rdata1);

`ifdef DMEM_RANGE_CHECK_EN
    // 6: out-of-range write is dropped; out-of-range read returns zero
    op(1'b1, 32'h0000_4000, L_C3, M_ALL, lat, e);
    chk("t6_wr_lat", 256'(lat), 256'(10));
    chk("t6_wr_err", 256'(e), 256'(1));
    @(posedge clk); #1;
    chk("t6_err_fall", 256'(err), 256'(0));
    op(1'b0, 32'h0, '0, '0, lat, e);
    chk("t6_line0", rdata, L_3C);
    chk("t6_rd_ok_err", 256'(e), 256'(0));
    op(1'b0, 32'h0000_4000, '0, '0, lat, e);
    chk("t6_rd_err", 256'(e), 256'(1));
    chk("t6_rd_zero", rdata, '0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
